// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte queue feeding a UART transmitter through the Transmit_Start / Tx_Busy handshake.
// Define UART_TXQ_ALMOST_FULL_EN to add the ALMOST_FULL_LEVEL parameter and the Almost_Full output.
module uart_tx_queue #(
    parameter int DATA_BITS   = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int ACK_TIMEOUT = 16384
`ifdef UART_TXQ_ALMOST_FULL_EN
    ,
    parameter int ALMOST_FULL_LEVEL = FIFO_DEPTH - 2
`endif
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic                          Wr_En,
    input  logic [DATA_BITS-1:0]          Wr_Data,
    input  logic                          Flush,
    input  logic                          Tx_Busy,
    output logic [DATA_BITS-1:0]          Tx_Data,
    output logic                          Transmit_Start,
    output logic                          Full,
    output logic                          Empty,
    output logic [$clog2(FIFO_DEPTH):0]   Count,
    output logic                          Wr_Overflow,
    output logic                          Ack_Timeout
`ifdef UART_TXQ_ALMOST_FULL_EN
    ,
    output logic                          Almost_Full
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(ACK_TIMEOUT);

    // Handshake: Transmit_Start is the valid for Tx_Data and stays high until the
    // transmitter raises Tx_Busy (its accept); the byte is finished when Tx_Busy
    // falls again. If Tx_Busy never rises within ACK_TIMEOUT cycles the byte is dropped.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [AW:0]          wr_ptr_q;
    logic [AW:0]          wr_ptr_d;
    logic [AW:0]          rd_ptr_q;
    logic [AW:0]          rd_ptr_d;
    logic [TW-1:0]        timer_q;
    logic [TW-1:0]        timer_d;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [DATA_BITS-1:0] tx_data_d;
    logic                 start_d;
    logic                 tout_d;
    logic                 ovf_d;
    logic                 wr_accept;
    logic                 pop;

    assign Empty = (wr_ptr_q == rd_ptr_q);
    assign Full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign Count = wr_ptr_q - rd_ptr_q;

    // Full comes from registered pointers, so a same-cycle pop never rescues a write.
    assign wr_accept = Wr_En && !Full && !Flush;
    assign ovf_d     = Wr_En && Full;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        tx_data_d = Tx_Data;
        start_d   = 1'b0;
        tout_d    = 1'b0;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!Empty && !Tx_Busy) begin
                    pop       = 1'b1;
                    tx_data_d = mem[rd_ptr_q[AW-1:0]];
                    timer_d   = '0;
                    start_d   = 1'b1;
                    state_d   = START;
                end
            end
            START: begin
                if (Tx_Busy) begin
                    state_d = WAIT_DONE;
                end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
                    tout_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                    start_d = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!Tx_Busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Flush clears only the pointers; an in-flight byte keeps its state and data.
    always_comb begin
        rd_ptr_d = rd_ptr_q + (AW + 1)'(pop);
        wr_ptr_d = wr_ptr_q + (AW + 1)'(wr_accept);
        if (Flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (wr_accept) begin
            mem[wr_ptr_q[AW-1:0]] <= Wr_Data;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            timer_q        <= '0;
            Tx_Data        <= '0;
            Transmit_Start <= 1'b0;
            Wr_Overflow    <= 1'b0;
            Ack_Timeout    <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            timer_q        <= timer_d;
            Tx_Data        <= tx_data_d;
            Transmit_Start <= start_d;
            Wr_Overflow    <= ovf_d;
            Ack_Timeout    <= tout_d;
        end
    end

`ifdef UART_TXQ_ALMOST_FULL_EN
    logic [AW:0] count_d;

    // Compared against the next-cycle occupancy so the flag lines up with Count.
    assign count_d = wr_ptr_d - rd_ptr_d;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            Almost_Full <= 1'b0;
        end else begin
            Almost_Full <= (32'(count_d) >= 32'(ALMOST_FULL_LEVEL));
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: directed vectors and sequences plus random traffic against a queue-level model.
`timescale 1ns/1ps
module tb_uart_tx_queue;

    localparam int W     = 8;
    localparam int DEPTH = 16;
    localparam int TOUT  = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          wr_en   = 1'b0;
    logic [W-1:0]  wr_data = '0;
    logic          flush   = 1'b0;
    logic          tx_busy = 1'b0;
    logic [W-1:0]  tx_data;
    logic          transmit_start;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          wr_overflow;
    logic          ack_timeout;
`ifdef UART_TXQ_ALMOST_FULL_EN
    logic          almost_full;
`endif

    uart_tx_queue #(
        .DATA_BITS  (W),
        .FIFO_DEPTH (DEPTH),
        .ACK_TIMEOUT(TOUT)
    ) dut (
        .Clk           (clk),
        .Rst           (rst_n),
        .Wr_En         (wr_en),
        .Wr_Data       (wr_data),
        .Flush         (flush),
        .Tx_Busy       (tx_busy),
        .Tx_Data       (tx_data),
        .Transmit_Start(transmit_start),
        .Full          (full),
        .Empty         (empty),
        .Count         (count),
        .Wr_Overflow   (wr_overflow),
        .Ack_Timeout   (ack_timeout)
`ifdef UART_TXQ_ALMOST_FULL_EN
        ,
        .Almost_Full   (almost_full)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0] exp_q[$];    // bytes waiting in the queue
    logic [W-1:0] sent_q[$];   // byte presented at each new Transmit_Start
    bit           m_xfer;      // a byte has been handed to the transmitter
    bit           m_acked;     // transmitter has answered with Tx_Busy
    int           m_start_cnt; // START cycles elapsed for the current byte
    logic [W-1:0] m_data;
    bit           m_start;
    bit           m_tout;
    bit           m_ovf;
    bit           prev_start;

    // ---------------- transmitter responder ----------------
    int resp_mode;   // 0: Tx_Busy driven by the test, 1: automatic
    bit resp_random;
    int resp_delay;
    int resp_hold;
    int r_wait;
    int r_hold;

    task automatic respond();
        if (resp_mode == 0) return;
        if (tx_busy) begin
            if (r_hold > 0) r_hold--;
            if (r_hold == 0) tx_busy = 1'b0;
        end else if (transmit_start) begin
            if (r_wait == 0 && resp_random) resp_delay = $urandom_range(0, 9);
            r_wait++;
            if (r_wait > resp_delay) begin
                tx_busy = 1'b1;
                r_hold  = resp_random ? int'($urandom_range(1, 5)) : resp_hold;
                r_wait  = 0;
            end
        end else begin
            r_wait = 0;
            if (resp_random && $urandom_range(0, 19) == 0) begin
                tx_busy = 1'b1;
                r_hold  = $urandom_range(1, 3);
            end
        end
    endtask

    // One clock: advance the model on what the DUT will sample, then compare.
    task automatic tick();
        bit acc;
        bit pop;
        acc    = wr_en && !flush && (exp_q.size() < DEPTH);
        m_ovf  = wr_en && (exp_q.size() >= DEPTH);
        pop    = !m_xfer && (exp_q.size() != 0) && !tx_busy;
        m_tout = 1'b0;
        if (m_xfer) begin
            if (!m_acked) begin
                if (tx_busy) m_acked = 1'b1;
                else if (m_start_cnt == TOUT) begin
                    m_xfer = 1'b0;
                    m_tout = 1'b1;
                end else m_start_cnt++;
            end else if (!tx_busy) begin
                m_xfer = 1'b0;
            end
        end
        if (pop) begin
            m_data      = exp_q.pop_front();
            m_xfer      = 1'b1;
            m_acked     = 1'b0;
            m_start_cnt = 1;
        end
        if (flush) exp_q.delete();
        else if (acc) exp_q.push_back(wr_data);
        m_start = m_xfer && !m_acked;

        @(posedge clk);
        #1;
        check("count", count, exp_q.size());
        check("empty", empty, exp_q.size() == 0);
        check("full", full, exp_q.size() == DEPTH);
        check("transmit_start", transmit_start, m_start);
        check("tx_data", tx_data, m_data);
        check("wr_overflow", wr_overflow, m_ovf);
        check("ack_timeout", ack_timeout, m_tout);
`ifdef UART_TXQ_ALMOST_FULL_EN
        check("almost_full", almost_full, exp_q.size() >= DEPTH - 2);
`endif
        if (transmit_start && !prev_start) sent_q.push_back(tx_data);
        prev_start = transmit_start;
        respond();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_data"}, tx_data, 0);
        check({tag, "_start"}, transmit_start, 0);
        check({tag, "_empty"}, empty, 1);
        check({tag, "_full"}, full, 0);
        check({tag, "_count"}, count, 0);
        check({tag, "_ovf"}, wr_overflow, 0);
        check({tag, "_tout"}, ack_timeout, 0);
`ifdef UART_TXQ_ALMOST_FULL_EN
        check({tag, "_almost_full"}, almost_full, 0);
`endif
    endtask

    task automatic clear_model();
        exp_q.delete();
        sent_q.delete();
        m_xfer = 0; m_acked = 0; m_start_cnt = 0; m_data = '0;
        m_start = 0; m_tout = 0; m_ovf = 0; prev_start = 0;
        resp_mode = 0; resp_random = 0; resp_delay = 0; resp_hold = 1;
        r_wait = 0; r_hold = 0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset(input string tag);
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        flush   = 1'b0;
        tx_busy = 1'b0;
        #1;
        check_reset_outputs(tag);
        clear_model();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic idle_ticks(input int n);
        wr_en = 1'b0;
        flush = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    typedef struct {
        bit           wr;
        logic [W-1:0] d;
        bit           fl;
        int           cnt;
        bit           emp;
        bit           ful;
        bit           ovf;
    } vec_t;

    initial begin
        int   n_start;
        int   n_tout;
        bit   got_tout;
        bit   found;
        vec_t vt[8];

        clear_model();
        do_reset("por");

        // -------- table vectors with the transmitter held busy --------
        vt[0] = '{1, 8'h11, 0, 1, 0, 0, 0};
        vt[1] = '{1, 8'h22, 0, 2, 0, 0, 0};
        vt[2] = '{0, 8'h00, 0, 2, 0, 0, 0};
        vt[3] = '{1, 8'h33, 1, 0, 1, 0, 0};
        vt[4] = '{1, 8'h44, 0, 1, 0, 0, 0};
        vt[5] = '{0, 8'h00, 1, 0, 1, 0, 0};
        vt[6] = '{1, 8'h55, 0, 1, 0, 0, 0};
        vt[7] = '{1, 8'h66, 0, 2, 0, 0, 0};
        tx_busy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_en   = vt[i].wr;
            wr_data = vt[i].d;
            flush   = vt[i].fl;
            tick();
            check("tbl_count", count, vt[i].cnt);
            check("tbl_empty", empty, vt[i].emp);
            check("tbl_full", full, vt[i].ful);
            check("tbl_ovf", wr_overflow, vt[i].ovf);
        end
        resp_mode = 1; resp_delay = 1; resp_hold = 2;
        idle_ticks(30);
        check("tbl_sent_n", sent_q.size(), 2);
        if (sent_q.size() == 2) begin
            check("tbl_sent0", sent_q[0], 8'h55);
            check("tbl_sent1", sent_q[1], 8'h66);
        end

        // -------- single byte 0xA5, Tx_Busy 2 cycles after start, held 20 --------
        do_reset("rst_a5");
        resp_mode = 1; resp_delay = 2; resp_hold = 20;
        wr_data = 8'hA5;
        n_start = 0;
        for (int c = 0; c < 30; c++) begin
            wr_en = (c == 0);
            tick();
            if (transmit_start) n_start++;
            if (c == 0) begin
                check("a5_empty_c1", empty, 0);
                check("a5_start_c1", transmit_start, 0);
            end
            if (c == 1) begin
                check("a5_start_c2", transmit_start, 1);
                check("a5_count_c2", count, 0);
            end
            if (c >= 1) check("a5_data", tx_data, 8'hA5);
        end
        check("a5_start_cycles", n_start, 3);
        check("a5_count_end", count, 0);

        // -------- reset mid-START with 3 bytes queued --------
        do_reset("rst_pre");
        tx_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'hC0 + W'(i);
            tick();
        end
        wr_en = 1'b0;
        check("mid_start_active", transmit_start, 1);
        check("mid_start_count", count, 3);
        do_reset("rst_mid");
        idle_ticks(10);
        check("post_rst_no_start", sent_q.size(), 0);
        check("post_rst_empty", empty, 1);

        // -------- burst of 17 writes while busy, then drain --------
        do_reset("rst_burst");
        tx_busy = 1'b1;
        n_tout = 0;
        for (int i = 0; i < 17; i++) begin
            wr_en   = 1'b1;
            wr_data = W'(i);
            tick();
            if (wr_overflow) n_tout++;
            if (i == 15) check("burst_full", full, 1);
            if (i == 14) check("burst_not_full", full, 0);
        end
        check("burst_ovf_pulses", n_tout, 1);
        resp_mode = 1; resp_delay = 0; resp_hold = 2;
        idle_ticks(160);
        check("burst_sent_n", sent_q.size(), 16);
        for (int i = 0; i < 16; i++) begin
            if (i < sent_q.size()) check("burst_order", sent_q[i], i);
        end

        // -------- handshake timeout, transmitter never answers --------
        do_reset("rst_tout");
        tx_busy = 1'b0;
        n_start = 0; n_tout = 0; got_tout = 0;
        for (int c = 0; c < 40; c++) begin
            wr_en   = (c < 2);
            wr_data = (c == 0) ? 8'h71 : 8'h72;
            tick();
            if (!got_tout && transmit_start) n_start++;
            if (ack_timeout) begin
                got_tout = 1'b1;
                n_tout++;
            end
        end
        check("tout_start_cycles", n_start, TOUT);
        check("tout_pulses", n_tout, 2);
        check("tout_sent_n", sent_q.size(), 2);
        if (sent_q.size() == 2) check("tout_second", sent_q[1], 8'h72);

        // -------- flush while 0x3C is in WAIT_DONE --------
        do_reset("rst_flush");
        resp_mode = 1; resp_delay = 1; resp_hold = 12;
        for (int i = 0; i < 5; i++) begin
            wr_en   = 1'b1;
            wr_data = (i == 0) ? 8'h3C : W'(i);
            tick();
        end
        wr_en = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (tx_busy && !transmit_start) found = 1'b1;
            else tick();
        end
        check("flush_reached_wait", found, 1);
        check("flush_count_before", count, 4);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_count_after", count, 0);
        check("flush_data_kept", tx_data, 8'h3C);
        idle_ticks(40);
        check("flush_sent_n", sent_q.size(), 1);

`ifdef UART_TXQ_ALMOST_FULL_EN
        // -------- almost-full threshold --------
        do_reset("rst_af");
        tx_busy = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            wr_en   = 1'b1;
            wr_data = W'(k);
            tick();
            check("af_rise", almost_full, k >= 14);
        end
        resp_mode = 1; resp_delay = 0; resp_hold = 1;
        idle_ticks(40);
        check("af_low_after_drain", almost_full, 0);
`endif

        // -------- random traffic --------
        do_reset("rst_rand");
        resp_mode = 1; resp_random = 1;
        for (int c = 0; c < 1200; c++) begin
            wr_en   = ($urandom_range(0, 99) < 45);
            wr_data = W'($urandom);
            flush   = ($urandom_range(0, 99) < 2);
            tick();
        end
        idle_ticks(300);
        check("rand_drained", count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_queue.md
# uart_tx_queue

Transmit-side buffer that sits directly upstream of the UART transmitter. It accepts bytes from the host in bursts through a write port with a full flag. It drains them one at a time into the transmitter's `Tx_Data` / `Transmit_Start` inputs, using `Tx_Busy` as the completion handshake. This complements the receive-side FIFO and lets the host queue a message without polling `Tx_Busy` between bytes.

## Interface

Parameters:
- `DATA_BITS`, 8: byte width; matches the UART `DATA_BITS`.
- `FIFO_DEPTH`, 16: queue entries; power of two, ≥2.
- `ACK_TIMEOUT`, 16384: max `Clk` cycles `Transmit_Start` is held waiting for `Tx_Busy`; ≥2.

Ports:
- `Clk`  in  1  single clock; all state on rising edge.
- `Rst`  in  1  asynchronous, active-low reset.
- `Wr_En`  in  1  host write strobe, one byte per cycle.
- `Wr_Data`  in  DATA_BITS  host byte.
- `Flush`  in  1  synchronous queue clear.
- `Tx_Busy`  in  1  from transmitter.
- `Tx_Data`  out  DATA_BITS  to transmitter.
- `Transmit_Start`  out  1  to transmitter.
- `Full`  out  1  queue full.
- `Empty`  out  1  queue empty.
- `Count`  out  $clog2(FIFO_DEPTH)+1  entries stored.
- `Wr_Overflow`  out  1  one-cycle pulse on a rejected write.
- `Ack_Timeout`  out  1  one-cycle pulse on a handshake timeout.
- `Almost_Full`  out  1  present only with `UART_TXQ_ALMOST_FULL_EN`.

## Operation

- Storage: register array with read/write pointers one bit wider than the address. Pointers wrap naturally.
  - `Empty` = pointers equal.
  - `Full` = addresses equal and MSBs differ.
  - `Count` = wr_ptr − rd_ptr, taken modulo 2^(addr+1).
- Write: accepted when `Wr_En` && !`Full`. When `Full`, the byte is dropped, `Wr_Overflow` pulses, and state is unchanged.
- `Full` is evaluated on the registered state. A write while full is rejected even if a pop occurs in the same cycle.
- A simultaneous write and pop on a non-full, non-empty queue leaves `Count` unchanged.
- FSM states:
  - IDLE: if !`Empty` && !`Tx_Busy` → latch the head into `Tx_Data`, advance rd_ptr, clear the timer, go to START.
  - START: `Transmit_Start`=1 and `Tx_Data` held stable.
    - On `Tx_Busy`=1 → go to WAIT_DONE.
    - If the timer reaches `ACK_TIMEOUT`−1 with no `Tx_Busy` → pulse `Ack_Timeout`, discard the byte, go to IDLE.
  - WAIT_DONE: `Transmit_Start`=0. When `Tx_Busy`=0 → go to IDLE.
- `Flush` resets both pointers to 0 and has priority over a write in the same cycle. It does not abort an in-flight byte: the FSM state and `Tx_Data` are untouched.
- `Tx_Data` holds the last byte sent until the next pop.
- Reset (any time, including mid-transfer): state IDLE, pointers 0, `Tx_Data`=0, `Transmit_Start`=0, `Empty`=1, `Full`=0, `Count`=0, `Wr_Overflow`=0, `Ack_Timeout`=0, `Almost_Full`=0.

## Timing

- All outputs are registered, except `Full`, `Empty` and `Count`, which are decoded combinationally from the registered pointers.
- Write at cycle 0 into an empty, idle queue:
  - `Empty`=0 at cycle 1.
  - `Tx_Data` valid and `Transmit_Start`=1 from cycle 2; `Count` returns to 0 at cycle 2.
- `Transmit_Start` deasserts in the cycle after `Tx_Busy` is sampled high.
- Back-to-back bytes: the next pop occurs in the cycle after `Tx_Busy` is sampled low in WAIT_DONE. This gives a minimum 1-cycle IDLE gap between start pulses.
- Timer width is $clog2(`ACK_TIMEOUT`). A timeout fires in the `ACK_TIMEOUT`-th START cycle.
- `Tx_Busy` already high in IDLE (BIST or another master driving the transmitter): no pop occurs. The queue waits.

## Configuration

- `UART_TXQ_ALMOST_FULL_EN` defined:
  - Adds parameter `ALMOST_FULL_LEVEL` (default `FIFO_DEPTH`−2).
  - Adds the registered output `Almost_Full`, asserted when the next-cycle `Count` ≥ `ALMOST_FULL_LEVEL`. It is therefore aligned with `Count`.
- Not defined: the port, the parameter and the compare logic are absent, and all other behaviour is identical.

## Test plan

- Reset low mid-START with 3 bytes queued → all outputs return to their reset values immediately. After release, `Empty`=1 and no `Transmit_Start` occurs.
- Write 0xA5 to an idle queue; model `Tx_Busy` high 2 cycles after `Transmit_Start`, held 20 cycles → `Transmit_Start` high from cycle 2 until 1 cycle after `Tx_Busy`; `Tx_Data`=0xA5 throughout; `Count` back to 0.
- Burst 17 writes (0x00–0x10) with `Tx_Busy` held high, DEPTH=16 → `Full`=1 after 16; `Wr_Overflow` pulses once on 0x10. Then release `Tx_Busy` → transmitted order is 0x00…0x0F, and no 0x10 appears.
- Hold `Tx_Busy`=0 and never respond, with 2 bytes queued and `ACK_TIMEOUT`=8 → `Ack_Timeout` pulses after 8 START cycles, first byte dropped; the second byte gets its own `Transmit_Start`.
- `Flush` while byte 0x3C is in WAIT_DONE with 4 queued → `Count`=0 next cycle; 0x3C completes normally; no further starts.
- With `UART_TXQ_ALMOST_FULL_EN`, DEPTH=16, `Tx_Busy`=1 → `Almost_Full` rises on the 14th accepted write and falls when `Count` drops to 13.
